// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between two requesters.
//   Port A (load/store stage) and port B (debug/DMA) each present
//   req/we/addr/wdata and get back a one-cycle gnt pulse, plus rvalid/rdata
//   for reads. At most one command per cycle is issued on mem_*. Contention
//   alternates fairly between the ports. Read data (one-cycle memory latency)
//   is routed back to the port that issued the read.
// Ports:
//   clk, rst (async, active-low)
//   a_req/a_we/a_addr/a_wdata -> a_gnt/a_rvalid/a_rdata   (port A)
//   b_req/b_we/b_addr/b_wdata -> b_gnt/b_rvalid/b_rdata   (port B)
//   mem_rd_en/mem_wr_en/mem_addr/mem_wr_data -> memory; mem_read_data <- memory
module dmem_arbiter #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [BUS_WIDTH-1:0] a_addr,
  input  logic [BUS_WIDTH-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [BUS_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [BUS_WIDTH-1:0] b_addr,
  input  logic [BUS_WIDTH-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [BUS_WIDTH-1:0] b_rdata,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wr_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data
);

  logic last;   // last port granted: 0=A, 1=B
  logic elig_a, elig_b, sel_vld, sel_b;

  // A port whose gnt is showing is still dropping its req; skip it this cycle.
  assign elig_a  = a_req & ~a_gnt;
  assign elig_b  = b_req & ~b_gnt;
  assign sel_vld = elig_a | elig_b;
  // B wins when it alone is eligible, or on contention when A went last.
  assign sel_b   = elig_b & (~elig_a | ~last);

  // Issue stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last        <= 1'b1;   // A wins the first contention after reset
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else if (sel_vld) begin
      last        <= sel_b;
      a_gnt       <= ~sel_b;
      b_gnt       <= sel_b;
      mem_addr    <= sel_b ? b_addr  : a_addr;
      mem_wr_data <= sel_b ? b_wdata : a_wdata;
      mem_wr_en   <= sel_b ? b_we    : a_we;
      mem_rd_en   <= sel_b ? ~b_we   : ~a_we;
    end else begin
      // idle: address/data hold, enables and grants drop
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
    end
  end

  // Return stage: tag the read with the port that owned the issue slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & mem_rd_en;
      b_rvalid <= b_gnt & mem_rd_en;
    end
  end

  assign a_rdata = a_rvalid ? mem_read_data : '0;
  assign b_rdata = b_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory
// (word-addressed, bit 0 ignored, one-cycle read latency).
module tb_dmem_arbiter;
  localparam int W = 16;

  logic         clk, rst;
  logic         a_req, a_we, b_req, b_we;
  logic [W-1:0] a_addr, a_wdata, b_addr, b_wdata;
  logic         a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [W-1:0] a_rdata, b_rdata;
  logic         mem_rd_en, mem_wr_en;
  logic [W-1:0] mem_addr, mem_wr_data, mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mem [0:255];

  dmem_arbiter #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[8:1]] <= mem_wr_data;
    if (mem_rd_en) mem_read_data <= mem[mem_addr[8:1]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h08] = 16'hBEEF;   // byte address 0x0010
    mem_read_data = '0;
    idle_reqs();
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
    rst = 0;
    tick(); tick();

    // reset state
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wr_data, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    rst = 1;

    // single read
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    tick();
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_rd_en", mem_rd_en, 1);
    chk("rd_addr", mem_addr, 16'h0010);
    a_req = 0;
    tick();
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'hBEEF);
    chk("rd_b_rvalid", b_rvalid, 0);
    chk("rd_b_rdata", b_rdata, 0);
    tick();

    // contention after reset: A, B, A, B
    do_reset();
    a_req = 1; a_addr = 16'h0010; b_req = 1; b_addr = 16'h0030;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("cont_a_gnt", a_gnt, (c % 2 == 1) ? 1 : 0);
      chk("cont_b_gnt", b_gnt, (c % 2 == 0) ? 1 : 0);
      chk("cont_one_gnt", a_gnt & b_gnt, 0);
    end
    idle_reqs();
    tick(); tick();

    // B writes 0x1234 @0x0020, A reads 0x0021 (same word)
    b_req = 1; b_we = 1; b_addr = 16'h0020; b_wdata = 16'h1234;
    tick();
    chk("wr_b_gnt", b_gnt, 1);
    chk("wr_wr_en", mem_wr_en, 1);
    chk("wr_rd_en", mem_rd_en, 0);
    idle_reqs();
    a_req = 1; a_we = 0; a_addr = 16'h0021;
    tick();
    chk("wr_b_rvalid", b_rvalid, 0);
    chk("wr_rd_a_gnt", a_gnt, 1);
    chk("wr_rd_addr", mem_addr, 16'h0021);
    a_req = 0;
    tick();
    chk("wr_rd_a_rvalid", a_rvalid, 1);
    chk("wr_rd_a_rdata", a_rdata, 16'h1234);
    chk("wr_rd_b_rvalid", b_rvalid, 0);
    tick();

    // single port held: gnt every other cycle
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("hold_a_gnt", a_gnt, (c % 2 == 1) ? 1 : 0);
      chk("hold_rd_en", mem_rd_en, (c % 2 == 1) ? 1 : 0);
      chk("hold_b_gnt", b_gnt, 0);
    end
    idle_reqs();
    tick(); tick();

    // reset during a read grant
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    tick();
    chk("rr_a_gnt", a_gnt, 1);
    #2 rst = 0;
    #1;
    chk("rr_async_a_gnt", a_gnt, 0);
    chk("rr_async_rd_en", mem_rd_en, 0);
    chk("rr_async_addr", mem_addr, 0);
    tick();
    chk("rr_a_rvalid", a_rvalid, 0);
    chk("rr_a_rdata", a_rdata, 0);
    #2 rst = 1;
    tick();
    chk("rr_regrant", a_gnt, 1);
    chk("rr_regrant_rd", mem_rd_en, 1);
    a_req = 0;
    tick(); tick();

    // idle hold after a write
    a_req = 1; a_we = 1; a_addr = 16'h0040; a_wdata = 16'h5555;
    tick();
    chk("ih_wr_en", mem_wr_en, 1);
    idle_reqs();
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("ih_wr_en0", mem_wr_en, 0);
      chk("ih_rd_en0", mem_rd_en, 0);
      chk("ih_addr", mem_addr, 16'h0040);
      chk("ih_wdata", mem_wr_data, 16'h5555);
      chk("ih_a_rvalid", a_rvalid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between two requesters. Port A is the processor load/store stage; port B is a secondary master (debug/DMA loader). It issues at most one memory command per cycle, alternates fairly between the ports, and routes the memory's one-cycle-latency read data back to whichever port issued the read. It sits directly between the requesters and the data memory's `rd_en` / `wr_en` / `addr` / `wr_data` / `read_data` pins.

## Interface
- BUS_WIDTH, 16, width of the address and data buses on all ports.

- clk  in  1  system clock; every register in the block updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low; `rst`=0 clears all state immediately.
- a_req  in  1  port A request. Held with stable we/addr/wdata until `a_gnt` is seen.
- a_we  in  1  port A: 1=write, 0=read.
- a_addr  in  BUS_WIDTH  port A byte address, passed through unmodified.
- a_wdata  in  BUS_WIDTH  port A write data.
- a_gnt  out  1  registered one-cycle pulse: port A's command is on the memory bus this cycle.
- a_rvalid  out  1  registered: `a_rdata` holds port A's read result this cycle.
- a_rdata  out  BUS_WIDTH  equals `mem_read_data` when `a_rvalid`=1, otherwise 0.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for port B.
- mem_rd_en  out  1  registered read enable to the data memory.
- mem_wr_en  out  1  registered write enable to the data memory.
- mem_addr  out  BUS_WIDTH  registered address to the data memory.
- mem_wr_data  out  BUS_WIDTH  registered write data to the data memory.
- mem_read_data  in  BUS_WIDTH  data-memory read output; valid the cycle after `mem_rd_en`.

## Operation
- State:
  - `last`: last port granted, 0=A, 1=B.
  - Issue stage: the `mem_*` outputs plus `a_gnt` / `b_gnt`.
  - Return stage: `a_rvalid` / `b_rvalid`.
- Eligibility each cycle:
  - `elig_A = a_req & ~a_gnt`; `elig_B = b_req & ~b_gnt`.
  - A port whose grant is currently showing is ineligible. This prevents a double grant while the requester is still deasserting `req`.
- Selection, combinational, registered at the next edge:
  - Both ports eligible: pick the port ≠ `last`.
  - One port eligible: pick that port.
  - Neither eligible: idle.
- On an edge with a selection S:
  - `mem_addr` <= S_addr.
  - `mem_wr_data` <= S_wdata.
  - `mem_wr_en` <= S_we; `mem_rd_en` <= ~S_we.
  - S_gnt <= 1; the other port's gnt <= 0.
  - `last` <= S.
- On an idle edge:
  - `mem_rd_en` = `mem_wr_en` = 0, and both gnt = 0.
  - `mem_addr` and `mem_wr_data` hold their previous values.
  - `last` is unchanged.
- Return stage, at each edge:
  - `a_rvalid` <= `a_gnt & mem_rd_en`.
  - `b_rvalid` <= `b_gnt & mem_rd_en`.
  - Writes produce no rvalid.
- `mem_rd_en` and `mem_wr_en` are mutually exclusive. At most one gnt and at most one rvalid are high in any cycle.
- Addresses are passed through unchanged. The memory ignores bit 0, so odd and even byte addresses of a pair hit the same word. The arbiter does no alignment checking.
- Ordering:
  - A write granted in cycle k is visible to a read granted in cycle k+1 or later.
  - Accesses are performed in grant order.
- Reset (`rst`=0):
  - Applies asynchronously at any time.
  - All outputs go to 0, including `mem_addr` / `mem_wr_data`, and `last` = 1, so A wins the first contention.
  - An in-flight read is discarded and its rvalid never asserts.
  - Requests held through reset are arbitrated from the first edge after `rst` returns to 1.

## Timing
- Read: req seen before edge N → gnt and `mem_rd_en` high during cycle N+1 → rvalid and rdata during cycle N+2. Request-to-data latency is 2 cycles.
- Write: req seen before edge N → gnt and `mem_wr_en` high during cycle N+1; the memory is updated at the end of N+1.
- Requester rule: drop `req`, or present the next command, in the cycle after the one where gnt is seen.
- Throughput:
  - 1 command per cycle when both ports keep requesting (A, B, A, B…).
  - At most 1 command every 2 cycles for a single port.
- No combinational path from any `*_req` input to any output. The `*_rdata` outputs are a gated copy of `mem_read_data`.

## Test plan
- **Single read:** memory word at 0x0010 preloaded with 0xBEEF; `a_req`=1, `a_we`=0, `a_addr`=0x0010 from cycle 0.
  - Cycle 1: `a_gnt`=1, `mem_rd_en`=1, `mem_addr`=0x0010.
  - Cycle 2: `a_rvalid`=1, `a_rdata`=0xBEEF; `b_rvalid`=0, `b_rdata`=0.
- **Contention after reset:** both ports request continuously.
  - Grants run A, B, A, B on cycles 1, 2, 3, 4.
  - Never two gnts in the same cycle.
- **Write then read:** B writes 0x1234 to 0x0020; A then reads 0x0021.
  - `a_rdata`=0x1234 two cycles after A's request is presented.
  - No rvalid is raised for the write.
- **Single port, req held constantly:** `a_req` held high, `b_req`=0.
  - `a_gnt` pulses every other cycle (1, 3, 5…).
  - `mem_rd_en` is 0 in the gaps.
- **Reset during a read:** `rst` pulled to 0 mid-cycle 1 during A's read grant.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - `a_rvalid` stays 0 in cycle 2.
  - After `rst`=1, a held `a_req` is granted on the next edge.
- **Idle hold:** after a write to 0x0040 with data 0x5555, both requests drop.
  - `mem_wr_en`=0 and `mem_rd_en`=0.
  - `mem_addr` stays 0x0040 and `mem_wr_data` stays 0x5555.
